log_mult_pipe: RTL and testbench
================================

# log_mult_pipe

Parametrised, pipelined Mitchell logarithmic multiplier for signed two's-complement operands. It is the streaming successor to the team's combinational log multiplier. It adds configurable operand width, mantissa truncation, an optional per-transaction constant error-correction mode, a passthrough tag, and a valid/ready handshake with full backpressure. It sits between operand producers and accumulation logic in the approximate-MAC datapath.

## Interface
Parameters:
- WIDTH, 16, operand width in bits (≥4); product is 2*WIDTH.
- KEEP, WIDTH-1, number of fraction MSBs retained after normalisation (1..WIDTH-1); lower fraction bits are forced to 0.
- TAG_W, 4, width of the sideband tag carried with each operation.

Ports:
- i_clk  in  1  clock. There is one clock.
- i_rst_n  in  1  reset. It is synchronous and active-low.
- i_valid  in  1  input operation valid.
- o_ready  out  1  block can accept an operation this cycle.
- i_a, i_b  in  WIDTH  signed operands.
- i_corr  in  1  correction mode for this operation.
- i_tag  in  TAG_W  sideband tag.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- o_z  out  2*WIDTH  signed approximate product.
- o_tag  out  TAG_W  tag of the operation in o_z.

## Operation
- An operation is accepted on a rising edge with i_valid && o_ready. i_a, i_b, i_corr and i_tag travel together through the pipe.
- Define F = WIDTH-1.
- **S1 (sign / LOD / normalise):**
  - sa = a[MSB], sb = b[MSB], sz = sa^sb.
  - |a| is computed as an unsigned WIDTH-bit value, so the most negative input gives 2^(WIDTH-1).
  - ka = position of the leading one (0..F).
  - fa = (|a| << (F-ka))[F-1:0], with bits below F-KEEP cleared. The same applies to b.
  - zero = (|a|==0) || (|b|==0).
- **S2 (log add):**
  - K = ka+kb, with width clog2(2F+1)+1.
  - S = fa + fb + (corr ? 2^(F-4) : 0), computed F+1 bits wide.
  - ovf = S ≥ 2^F. The overflow test is applied to the corrected sum.
- **S3 (antilog / sign):**
  - If !ovf: mag = ((2^F + S) << K) >> F.
  - If ovf: mag = (S << (K+1)) >> F.
  - Intermediates are wide enough that nothing is lost before the right shift. The right shift truncates toward zero.
  - If zero, mag = 0.
  - o_z = sz ? -mag : mag. A zero magnitude always gives o_z = 0.
- There is no saturation. The product always fits in 2*WIDTH signed bits.

## Timing
- Three register stages. Latency is 3 cycles from acceptance to o_valid with no stall. Throughput is 1 op/cycle.
- Each stage n has a valid bit vn.
- Stage n loads when !vn or when stage n drains this cycle. The output stage drains on o_valid && i_ready.
- o_ready = !v1 || (stage 1 drains).
- Bubbles collapse: an empty downstream stage accepts even while the output is stalled.
- While o_valid && !i_ready, o_z and o_tag are held stable. With all stages full, o_ready = 0.
- Back-to-back accept and drain in the same cycle sustains full throughput with no bubble.
- Reset (i_rst_n low at an edge) clears all valid bits. After reset: o_valid = 0, o_z = 0, o_tag = 0, o_ready = 1 from the first cycle after reset.
- Reset mid-operation discards all in-flight operations and no partial results are emitted.
- Data registers do not need reset, except the output o_z and o_tag registers.

## Test plan
- **Basic products** (WIDTH=16, corr=0, streamed back-to-back, i_ready=1):
  - 3*5 → 14.
  - -3*5 → -14.
  - 7*7 → 48.
  - 256*-128 → -32768.
  - All emerge on consecutive cycles starting 3 cycles after the first accept.
- **Correction:** 7*7 with corr=1 → 50; 3*5 with corr=1 → 14. Mode is interleaved per operation with corr=0 ops, and each result must use its own mode.
- **Boundaries:**
  - -32768*-32768 → 1073741824.
  - 0*-5 → 0.
  - -1*-1 → 1.
  - 1*-32768 → -32768.
- **Truncation:** KEEP=1 instance, 5*5 → 16. The default instance gives 5*5 → 24.
- **Backpressure:**
  - Hold i_ready=0 for 5 cycles with continuous input. o_ready must drop after 3 accepts. o_z and o_tag must stay stable.
  - On release, all results appear in order with tags intact, none lost or duplicated.
  - Randomised i_valid/i_ready over 10k ops, checked against a reference model.
- **Reset:** assert i_rst_n=0 with 3 ops in flight. Next cycle: o_valid=0, o_z=0. No stale result ever appears. The first post-reset op emerges after 3 cycles.

Source files
------------

// File: rtl/log_mult_pipe.sv
// log_mult_pipe: three-stage Mitchell logarithmic multiplier for signed operands.
// S1 takes sign, leading-one position and truncated fraction; S2 adds the logs
// (with optional constant correction); S3 takes the antilog and reapplies sign.
module log_mult_pipe #(
    parameter int WIDTH = 16,
    parameter int KEEP  = WIDTH - 1,
    parameter int TAG_W = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic signed [WIDTH-1:0]   i_a,
    input  logic signed [WIDTH-1:0]   i_b,
    input  logic                      i_corr,
    input  logic [TAG_W-1:0]          i_tag,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic signed [2*WIDTH-1:0] o_z,
    output logic [TAG_W-1:0]          o_tag
);
    localparam int F    = WIDTH - 1;
    localparam int KA_W = $clog2(WIDTH);
    localparam int KW   = $clog2(2 * F + 1) + 1;
    localparam int PW   = 2 * WIDTH;
    localparam int XW   = 3 * WIDTH + 2;
    localparam int CSH  = (F >= 4) ? F - 4 : 0;

    localparam logic [WIDTH-1:0] ONE_W    = 1;
    localparam logic [F-1:0]     FMASK    = {F{1'b1}} << (F - KEEP);
    localparam logic [F:0]       CORR_ADD = (F >= 4) ? ((F + 1)'(1) << CSH) : '0;
    localparam logic [XW-1:0]    HIDDEN   = XW'(1) << F;

    // Handshake: a stage loads when it is empty or when its contents move on
    // in the same cycle; the output stage moves on when o_valid && i_ready.
    // An op is accepted on a clock edge where i_valid && o_ready.
    logic v1_q, v2_q, v3_q;
    logic load1, load2, load3;

    assign load3   = !v3_q || i_ready;
    assign load2   = !v2_q || load3;
    assign load1   = !v1_q || load2;
    assign o_ready = load1;
    assign o_valid = v3_q;

    function automatic logic [KA_W-1:0] lod(input logic [WIDTH-1:0] v);
        lod = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) lod = KA_W'(i);
        end
    endfunction

    function automatic logic [F-1:0] norm(input logic [WIDTH-1:0] v, input logic [KA_W-1:0] k);
        logic [WIDTH-1:0] sh;
        sh   = v << (KA_W'(F) - k);
        norm = sh[F-1:0] & FMASK;
    endfunction

    // Stage 1 next-state: magnitudes, leading-one positions, truncated fractions.
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [KA_W-1:0]  s1_ka_d, s1_kb_d;
    logic [F-1:0]     s1_fa_d, s1_fb_d;
    logic             s1_sz_d, s1_zero_d;

    always_comb begin
        abs_a     = i_a[WIDTH-1] ? (~$unsigned(i_a) + ONE_W) : $unsigned(i_a);
        abs_b     = i_b[WIDTH-1] ? (~$unsigned(i_b) + ONE_W) : $unsigned(i_b);
        s1_ka_d   = lod(abs_a);
        s1_kb_d   = lod(abs_b);
        s1_fa_d   = norm(abs_a, s1_ka_d);
        s1_fb_d   = norm(abs_b, s1_kb_d);
        s1_sz_d   = i_a[WIDTH-1] ^ i_b[WIDTH-1];
        s1_zero_d = (abs_a == '0) || (abs_b == '0);
    end

    logic [KA_W-1:0]  s1_ka_q, s1_kb_q;
    logic [F-1:0]     s1_fa_q, s1_fb_q;
    logic             s1_sz_q, s1_zero_q, s1_corr_q;
    logic [TAG_W-1:0] s1_tag_q;

    // Stage 2 next-state: log-domain sum of characteristics and mantissas.
    logic [KW-1:0] s2_k_d;
    logic [F:0]    s2_s_d;

    always_comb begin
        s2_k_d = KW'(s1_ka_q) + KW'(s1_kb_q);
        s2_s_d = {1'b0, s1_fa_q} + {1'b0, s1_fb_q} + (s1_corr_q ? CORR_ADD : '0);
    end

    logic [KW-1:0]    s2_k_q;
    logic [F:0]       s2_s_q;
    logic             s2_sz_q, s2_zero_q;
    logic [TAG_W-1:0] s2_tag_q;

    // Stage 3 next-state: antilog with overflow handling, then sign.
    logic [XW-1:0] mant, wide;
    logic [KW-1:0] shamt;
    logic [PW-1:0] mag, o_z_d;

    always_comb begin
        if (s2_s_q[F]) begin
            mant  = XW'(s2_s_q);
            shamt = s2_k_q + KW'(1);
        end else begin
            mant  = XW'(s2_s_q) + HIDDEN;
            shamt = s2_k_q;
        end
        wide  = (mant << shamt) >> F;
        mag   = s2_zero_q ? '0 : wide[PW-1:0];
        o_z_d = s2_sz_q ? -mag : mag;
    end

    logic [PW-1:0]    o_z_q;
    logic [TAG_W-1:0] o_tag_q;

    assign o_z   = o_z_q;
    assign o_tag = o_tag_q;

    // Stage valid bits; reset drops every in-flight op.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            if (load1) v1_q <= i_valid;
            if (load2) v2_q <= v1_q;
            if (load3) v3_q <= v2_q;
        end
    end

    // Internal stage data; contents are don't-care while the valid bit is low.
    always_ff @(posedge i_clk) begin
        if (load1 && i_valid) begin
            s1_ka_q   <= s1_ka_d;
            s1_kb_q   <= s1_kb_d;
            s1_fa_q   <= s1_fa_d;
            s1_fb_q   <= s1_fb_d;
            s1_sz_q   <= s1_sz_d;
            s1_zero_q <= s1_zero_d;
            s1_corr_q <= i_corr;
            s1_tag_q  <= i_tag;
        end
        if (load2 && v1_q) begin
            s2_k_q    <= s2_k_d;
            s2_s_q    <= s2_s_d;
            s2_sz_q   <= s1_sz_q;
            s2_zero_q <= s1_zero_q;
            s2_tag_q  <= s1_tag_q;
        end
    end

    // Output registers; held while the result is stalled, cleared by reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_z_q   <= '0;
            o_tag_q <= '0;
        end else if (load3 && v2_q) begin
            o_z_q   <= o_z_d;
            o_tag_q <= s2_tag_q;
        end
    end

endmodule

// File: tb/tb_log_mult_pipe.sv
// Bench for log_mult_pipe: directed products, correction, boundaries,
// truncation, backpressure, reset and a randomized run against a model.
module tb_log_mult_pipe;
  localparam int WIDTH = 16;
  localparam int TAG_W = 4;
  localparam int PW    = 32;
  localparam int F     = WIDTH - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- DUT (default KEEP) ----------------
  logic             i_valid, o_ready, i_corr, o_valid, i_ready;
  logic [WIDTH-1:0] i_a, i_b;
  logic [TAG_W-1:0] i_tag, o_tag;
  logic [PW-1:0]    o_z;

  log_mult_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_corr(i_corr), .i_tag(i_tag),
    .o_valid(o_valid), .i_ready(i_ready), .o_z(o_z), .o_tag(o_tag)
  );

  // ---------------- DUT (KEEP=1) ----------------
  logic             k_valid, k_oready, k_corr, k_ovalid, k_iready;
  logic [WIDTH-1:0] k_a, k_b;
  logic [TAG_W-1:0] k_tag, k_otag;
  logic [PW-1:0]    k_z;

  log_mult_pipe #(.WIDTH(WIDTH), .KEEP(1), .TAG_W(TAG_W)) dut_k1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(k_valid), .o_ready(k_oready),
    .i_a(k_a), .i_b(k_b), .i_corr(k_corr), .i_tag(k_tag),
    .o_valid(k_ovalid), .i_ready(k_iready), .o_z(k_z), .o_tag(k_otag)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: Mitchell product computed with plain integer arithmetic.
  function automatic longint model(input logic [15:0] a, input logic [15:0] b,
                                   input logic corr, input int keep);
    longint av, bv, aa, bb, fa, fb, s, mag, p2f;
    int ka, kb, k;
    bit neg;
    av  = longint'($signed(a));
    bv  = longint'($signed(b));
    neg = (av < 0) != (bv < 0);
    aa  = (av < 0) ? -av : av;
    bb  = (bv < 0) ? -bv : bv;
    if (aa == 0 || bb == 0) return 0;
    ka = 0;
    while ((aa >> (ka + 1)) != 0) ka++;
    kb = 0;
    while ((bb >> (kb + 1)) != 0) kb++;
    p2f = longint'(1) << F;
    fa  = (aa << (F - ka)) % p2f;
    fb  = (bb << (F - kb)) % p2f;
    fa  = fa - (fa % (longint'(1) << (F - keep)));
    fb  = fb - (fb % (longint'(1) << (F - keep)));
    s   = (fa + fb + (corr ? (longint'(1) << (F - 4)) : 0)) % (2 * p2f);
    k   = ka + kb;
    if (s < p2f) mag = ((p2f + s) << k) >> F;
    else         mag = (s << (k + 1)) >> F;
    return neg ? -mag : mag;
  endfunction

  // ---------------- scoreboard ----------------
  logic [TAG_W+PW-1:0] exp_q[$];
  int                  out_cyc_q[$];
  logic [TAG_W+PW-1:0] mon_e;
  int                  last_acc;

  always @(negedge clk) begin
    if (rst_n && o_valid && i_ready) begin
      out_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("spurious_out", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_z", 64'(o_z), 64'(mon_e[PW-1:0]));
        check("out_tag", 64'(o_tag), 64'(mon_e[TAG_W+PW-1:PW]));
      end
    end
  end

  // Random downstream readiness when enabled.
  bit rnd_ready = 0;
  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      i_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  // Called 1 time unit after a rising edge; returns at the same phase.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic corr,
                      input logic [3:0] tag, input logic [31:0] ez);
    int  waited = 0;
    bit  done = 0;
    i_a = a; i_b = b; i_corr = corr; i_tag = tag; i_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (o_ready) begin
        exp_q.push_back({tag, ez});
        last_acc = cyc;
        done = 1;
      end else if (++waited > 200) begin
        check("accept_timeout", 64'd0, 64'd1);
        done = 1;
      end
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
  endtask

  logic [15:0] specials[5] = '{16'h8000, 16'h0000, 16'hFFFF, 16'h0001, 16'h7FFF};

  task automatic send_rand();
    logic [15:0] a, b;
    logic        c;
    logic [3:0]  t;
    a = ($urandom_range(0, 7) == 0) ? specials[$urandom_range(0, 4)] : 16'($urandom);
    b = ($urandom_range(0, 7) == 0) ? specials[$urandom_range(0, 4)] : 16'($urandom);
    c = 1'($urandom_range(0, 1));
    t = 4'($urandom);
    send(a, b, c, t, 32'(model(a, b, c, F)));
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc0, accepts, waited;
    bit need_new;
    rst_n = 1'b0; i_valid = 1'b0; i_a = '0; i_b = '0; i_corr = 1'b0; i_tag = '0; i_ready = 1'b1;
    k_valid = 1'b0; k_a = '0; k_b = '0; k_corr = 1'b0; k_tag = '0; k_iready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_o_valid", 64'(o_valid), 64'd0);
    check("rst_o_z", 64'(o_z), 64'd0);
    check("rst_o_tag", 64'(o_tag), 64'd0);
    check("rst_o_ready", 64'(o_ready), 64'd1);
    @(posedge clk); #1;

    // Basic products, back to back, with latency/throughput check
    out_cyc_q.delete();
    send(16'd3, 16'd5, 1'b0, 4'd1, 32'd14);
    acc0 = last_acc;
    send(16'(-3), 16'd5, 1'b0, 4'd2, 32'(-14));
    send(16'd7, 16'd7, 1'b0, 4'd3, 32'd48);
    send(16'd256, 16'(-128), 1'b0, 4'd4, 32'(-32768));
    wait_drain(20);
    check("basic_count", 64'(out_cyc_q.size()), 64'd4);
    for (int i = 0; i < out_cyc_q.size(); i++)
      check("basic_latency", 64'(out_cyc_q[i] - acc0), 64'(3 + i));

    // Correction interleaved with plain ops
    send(16'd7, 16'd7, 1'b1, 4'd5, 32'd50);
    send(16'd7, 16'd7, 1'b0, 4'd6, 32'd48);
    send(16'd3, 16'd5, 1'b1, 4'd7, 32'd14);
    send(16'd5, 16'd5, 1'b0, 4'd8, 32'd24);
    wait_drain(20);

    // Boundaries
    send(16'h8000, 16'h8000, 1'b0, 4'd9, 32'd1073741824);
    send(16'd0, 16'(-5), 1'b0, 4'd10, 32'd0);
    send(16'hFFFF, 16'hFFFF, 1'b0, 4'd11, 32'd1);
    send(16'd1, 16'h8000, 1'b0, 4'd12, 32'(-32768));
    wait_drain(20);

    // Truncation on the KEEP=1 instance
    k_a = 16'd5; k_b = 16'd5; k_tag = 4'd3; k_valid = 1'b1;
    @(negedge clk);
    check("k1_ready", 64'(k_oready), 64'd1);
    @(posedge clk); #1;
    k_valid = 1'b0;
    waited = 0;
    @(negedge clk);
    while (!k_ovalid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("k1_valid", 64'(k_ovalid), 64'd1);
    check("k1_z", 64'(k_z), 64'd16);
    check("k1_tag", 64'(k_otag), 64'd3);
    @(posedge clk); #1;

    // Backpressure: 5 stalled cycles with continuous input
    i_ready = 1'b0;
    accepts = 0;
    need_new = 1;
    for (int c = 0; c < 5; c++) begin
      if (need_new) begin
        i_a = 16'($urandom); i_b = 16'($urandom); i_corr = 1'($urandom_range(0, 1));
        i_tag = 4'(c + 1);
      end
      i_valid = 1'b1;
      @(negedge clk);
      check("bp_ready", 64'(o_ready), (c < 3) ? 64'd1 : 64'd0);
      need_new = o_ready;
      if (o_ready) begin
        exp_q.push_back({i_tag, 32'(model(i_a, i_b, i_corr, F))});
        accepts++;
      end
      if (c >= 3) begin
        check("bp_valid", 64'(o_valid), 64'd1);
        check("bp_hold_z", 64'(o_z), 64'(exp_q[0][PW-1:0]));
        check("bp_hold_tag", 64'(o_tag), 64'(exp_q[0][TAG_W+PW-1:PW]));
      end
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    check("bp_accepts", 64'(accepts), 64'd3);
    i_ready = 1'b1;
    wait_drain(20);

    // Reset with three ops in flight
    i_ready = 1'b0;
    send_rand();
    send_rand();
    send_rand();
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    i_ready = 1'b1;
    @(negedge clk);
    check("rst2_o_valid", 64'(o_valid), 64'd0);
    check("rst2_o_z", 64'(o_z), 64'd0);
    check("rst2_o_tag", 64'(o_tag), 64'd0);
    check("rst2_o_ready", 64'(o_ready), 64'd1);
    @(posedge clk); #1;
    repeat (6) begin
      @(posedge clk); #1;
    end
    out_cyc_q.delete();
    send(16'd7, 16'd7, 1'b1, 4'd9, 32'd50);
    wait_drain(20);
    check("rst2_count", 64'(out_cyc_q.size()), 64'd1);
    if (out_cyc_q.size() > 0)
      check("rst2_latency", 64'(out_cyc_q[0] - last_acc), 64'd3);

    // Randomized valid/ready over 10k ops
    rnd_ready = 1;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send_rand();
    end
    i_ready = 1'b1;
    wait_drain(500);
    rnd_ready = 0;
    @(posedge clk); #1;
    i_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
